vga_timing: RTL
===============

# vga_timing

Generates the XGA 1024x768 @ 60 Hz raster (65 MHz pixel clock) that drives the display pipeline. Produces registered horizontal/vertical counts, sync and blanking flags, all aligned to the same pixel. Sits directly upstream of draw_background, whose *_in timing ports it feeds. Also emits a one-cycle start-of-frame strobe that game logic uses for per-frame updates.

## Interface
Parameters:
- H_ACTIVE, 1024, visible pixels per line
- H_FP, 24, horizontal front porch
- H_SYNC, 136, horizontal sync width
- H_BP, 160, horizontal back porch (H_TOTAL = 1344)
- V_ACTIVE, 768, visible lines
- V_FP, 3, vertical front porch
- V_SYNC, 6, vertical sync width
- V_BP, 29, vertical back porch (V_TOTAL = 806)

Ports:
- pclk  in  1  pixel clock, 65 MHz; the block's only clock
- rst  in  1  reset, synchronous, active-low
- hcount_out  out  11  horizontal pixel index, 0..H_TOTAL-1
- hsync_out  out  1  high during horizontal sync window
- hblnk_out  out  1  high outside the visible horizontal region
- vcount_out  out  11  line index, 0..V_TOTAL-1
- vsync_out  out  1  high during vertical sync window
- vblnk_out  out  1  high outside the visible vertical region
- frame_tick  out  1  one-cycle pulse when the raster enters (0,0)
- frame_cnt  out  16  frame counter (see Configuration)

One clock, pclk. Reset is synchronous and active-low.

## Operation
- Two cascaded counters. hcount increments every cycle and wraps from H_TOTAL-1 to 0. vcount increments only on that h-wrap and wraps from V_TOTAL-1 to 0.
- Flags are decoded from the next-state counts and registered together with them, so every output in a cycle describes the same pixel.
- hblnk = hcount ≥ H_ACTIVE (1024..1343).
- hsync = H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC (1048..1183).
- vblnk = vcount ≥ V_ACTIVE (768..805).
- vsync = V_ACTIVE+V_FP ≤ vcount < V_ACTIVE+V_FP+V_SYNC (771..776).
- Syncs are active-high in logic. Pad polarity inversion happens at the top level, not here.
- frame_tick is high exactly in the cycle where the outputs show (0,0) after a wrap from (1343,805). It is never high in the reset-release frame.

## Timing
- Reset (rst=0 at an edge): next cycle, hcount_out=0, vcount_out=0, all flags 0, frame_tick=0, frame_cnt=0.
- First edge with rst=1: outputs show (1,0). The raster proceeds 1 pixel per cycle with no stalls.
- Line period is 1344 cycles. Frame period is 1344*806 = 1,083,264 cycles.
- Wrap (1343,805) → (0,0) occurs in a single edge. frame_tick rises in that same cycle and falls on the next.
- Wrap (1343,v) → (0,v+1) for v<805. frame_tick stays 0.
- Reset asserted mid-frame takes priority: the next cycle shows (0,0) with frame_tick=0 and no partial-frame count increment.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- VGA_TIMING_FRAME_CNT_EN defined: frame_cnt increments by 1, modulo 2^16, in the cycle frame_tick is high. It wraps from 0xFFFF to 0 and is cleared by reset.
- Macro undefined: frame_cnt is tied to 0 and the counter logic is absent. All other behaviour is identical.

## Structure
- Shared package/include vga_pkg holds the XGA constants (H_ACTIVE, H_TOTAL, sync start/end, V equivalents) and the 11-bit count width. Downstream draw stages use the same constants for screen bounds.
- Natural sub-module: mod_counter, an 11-bit wrap-at-N counter with increment enable and terminal-count output. It is instantiated twice, with the h terminal count driving the v enable.

## Test plan
- Reset held 5 cycles, then released → first cycle shows (0,0), all flags 0; the next shows (1,0); frame_tick stays 0.
- Run one line → hblnk rises at hcount=1024. hsync is high for hcount 1048..1183 only (136 cycles). At 1343→0, vcount increments to 1.
- Run a full frame → vblnk is high for vcount 768..805. vsync is high for lines 771..776 (6*1344 cycles). frame_tick pulses once at cycle 1,083,264 after the first (0,0).
- Assert rst at (500,300) for one cycle → next output is (0,0), flags 0, frame_tick 0; the count then resumes from (1,0).
- With VGA_TIMING_FRAME_CNT_EN, run 3 frames → frame_cnt = 3. Force the counter to 0xFFFF and cross a frame boundary → frame_cnt = 0. Without the macro, frame_cnt stays 0 throughout.

Source files
------------

// File: rtl/vga_pkg.sv
// XGA 1024x768@60 raster constants shared by the timing generator and the draw stages.
package vga_pkg;

    localparam int CNT_W = 11;

    typedef logic [CNT_W-1:0] count_t;

    localparam int H_ACTIVE = 1024;
    localparam int H_FP     = 24;
    localparam int H_SYNC   = 136;
    localparam int H_BP     = 160;
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int H_SYNC_END   = H_ACTIVE + H_FP + H_SYNC;

    localparam int V_ACTIVE = 768;
    localparam int V_FP     = 3;
    localparam int V_SYNC   = 6;
    localparam int V_BP     = 29;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;
    localparam int V_SYNC_END   = V_ACTIVE + V_FP + V_SYNC;

    // True when lo <= value < hi.
    function automatic logic in_window(input count_t value, input count_t lo, input count_t hi);
        return (value >= lo) && (value < hi);
    endfunction

endpackage

// File: rtl/mod_counter.sv
// Wrap-at-N counter with increment enable; exposes the next-state count and terminal count.
module mod_counter
    import vga_pkg::*;
#(
    parameter int N = 2
) (
    input  logic   clk_i,
    input  logic   rstn_i,
    input  logic   en_i,
    output count_t count_o,
    output count_t count_d_o,
    output logic   tc_o
);

    localparam count_t LAST = count_t'(N - 1);

    count_t count_q;
    count_t count_d;
    logic   tc;

    assign tc = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = tc ? '0 : count_q + count_t'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign count_d_o = count_d;
    assign tc_o      = tc;

endmodule

// File: rtl/vga_timing.sv
// XGA raster timing: registered h/v counts, sync/blank flags and start-of-frame strobe.
// Define VGA_TIMING_FRAME_CNT_EN to enable the 16-bit frame counter on frame_cnt.
module vga_timing #(
    parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int H_FP     = vga_pkg::H_FP,
    parameter int H_SYNC   = vga_pkg::H_SYNC,
    parameter int H_BP     = vga_pkg::H_BP,
    parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int V_FP     = vga_pkg::V_FP,
    parameter int V_SYNC   = vga_pkg::V_SYNC,
    parameter int V_BP     = vga_pkg::V_BP
) (
    input  logic        pclk,
    input  logic        rst,
    output logic [10:0] hcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [10:0] vcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic        frame_tick,
    output logic [15:0] frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam vga_pkg::count_t H_BLNK_START = vga_pkg::count_t'(H_ACTIVE);
    localparam vga_pkg::count_t H_SYNC_START = vga_pkg::count_t'(H_ACTIVE + H_FP);
    localparam vga_pkg::count_t H_SYNC_END   = vga_pkg::count_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam vga_pkg::count_t V_BLNK_START = vga_pkg::count_t'(V_ACTIVE);
    localparam vga_pkg::count_t V_SYNC_START = vga_pkg::count_t'(V_ACTIVE + V_FP);
    localparam vga_pkg::count_t V_SYNC_END   = vga_pkg::count_t'(V_ACTIVE + V_FP + V_SYNC);

    vga_pkg::count_t hcount_d;
    vga_pkg::count_t vcount_d;
    logic            h_tc;
    logic            v_tc;

    logic hsync_q;
    logic hblnk_q;
    logic vsync_q;
    logic vblnk_q;
    logic frame_tick_q;

    mod_counter #(.N(H_TOTAL)) u_hcnt (
        .clk_i     (pclk),
        .rstn_i    (rst),
        .en_i      (1'b1),
        .count_o   (hcount_out),
        .count_d_o (hcount_d),
        .tc_o      (h_tc)
    );

    // The line counter only advances on the horizontal wrap.
    mod_counter #(.N(V_TOTAL)) u_vcnt (
        .clk_i     (pclk),
        .rstn_i    (rst),
        .en_i      (h_tc),
        .count_o   (vcount_out),
        .count_d_o (vcount_d),
        .tc_o      (v_tc)
    );

    // Flags come from the next-state counts so they line up with the registered counts.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            hsync_q      <= 1'b0;
            hblnk_q      <= 1'b0;
            vsync_q      <= 1'b0;
            vblnk_q      <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            hblnk_q      <= (hcount_d >= H_BLNK_START);
            hsync_q      <= vga_pkg::in_window(hcount_d, H_SYNC_START, H_SYNC_END);
            vblnk_q      <= (vcount_d >= V_BLNK_START);
            vsync_q      <= vga_pkg::in_window(vcount_d, V_SYNC_START, V_SYNC_END);
            frame_tick_q <= h_tc && v_tc;
        end
    end

    assign hsync_out  = hsync_q;
    assign hblnk_out  = hblnk_q;
    assign vsync_out  = vsync_q;
    assign vblnk_out  = vblnk_q;
    assign frame_tick = frame_tick_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Updates on the same edge as frame_tick, so the new count appears with the strobe.
    always_ff @(posedge pclk) begin
        if (!rst) begin
            frame_cnt_q <= '0;
        end else if (h_tc && v_tc) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = '0;
`endif

endmodule
